// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite zero-wait-state SRAM slave. One byte-wide memory lane per data byte;
// writes commit at the end of the data phase, read data is captured at the address-phase edge.

module ahb3lite_sram_lane #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    input  logic          fwd,
    output logic [7:0]    rdata
);
    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // A write committing on this same edge is not in mem yet, so it is forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rdata <= '0;
        else if (rd_en) rdata <= fwd ? wdata : mem[raddr];
    end
endmodule

module ahb3lite_sram_slave #(
    parameter int MEM_SIZE   = 64,
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [HDATA_SIZE-1:0] HRDATA
);
    localparam int NUM_LANES = HDATA_SIZE / 8;
    localparam int LB        = $clog2(NUM_LANES);
    localparam int MB        = $clog2(MEM_SIZE);
    localparam int AW        = MB - LB;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [LB-1:0] lo;
        logic          write;
        logic [2:0]    size;
    } req_t;

    req_t                      req_d, req_q;
    logic                      acc, dph_vld, rd_en, unused_ok;
    logic [NUM_LANES-1:0]      lane_en, we, fwd;
    logic [NUM_LANES-1:0][7:0] wdata_lanes, rdata_lanes;

    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;
    assign acc         = HSEL & HREADY & HTRANS[1];
    assign rd_en       = acc & ~HWRITE;
    assign wdata_lanes = HWDATA;
    assign HRDATA      = rdata_lanes;
    assign unused_ok   = ^{HBURST, HPROT, HTRANS[0], HADDR[HADDR_SIZE-1:MB]};

    always_comb begin
        req_d       = '0;
        req_d.idx   = HADDR[MB-1:LB];
        req_d.lo    = HADDR[LB-1:0];
        req_d.write = HWRITE;
        req_d.size  = HSIZE;
    end

    // Clearing dph_vld asynchronously is what drops an in-flight write on reset.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dph_vld <= 1'b0;
            req_q   <= '0;
        end else begin
            dph_vld <= acc;
            if (acc) req_q <= req_d;
        end
    end

    // A lane is enabled when it sits in the same size-aligned group as the address.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_en[l] = (int'(req_q.size) >= LB) ||
                         ((l >> req_q.size) == (int'(req_q.lo) >> req_q.size));
            we[l]      = dph_vld & req_q.write & lane_en[l];
            fwd[l]     = we[l] & (req_q.idx == req_d.idx);
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ahb3lite_sram_lane #(.AW(AW)) u_lane (
            .clk   (HCLK),
            .rst   (HRESET),
            .we    (we[g]),
            .waddr (req_q.idx),
            .wdata (wdata_lanes[g]),
            .rd_en (rd_en),
            .raddr (req_d.idx),
            .fwd   (fwd[g]),
            .rdata (rdata_lanes[g])
        );
    end
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: vector table driven through a pipelined beat task,
// byte-array reference model feeding a read scoreboard, plus a reset-mid-write sequence.

module tb_ahb3lite_sram_slave;
    logic        HCLK = 1'b0;
    logic        HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [15:0] HADDR;
    logic [31:0] HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          ready;
        bit          write;
        logic [2:0]  size;
        logic [15:0] addr;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [7:0]  mem_m [64];
    logic [31:0] rdq[$];
    logic [31:0] last_rd, prev_wdata;
    bit          pend_w;
    logic [15:0] pend_addr;
    logic [2:0]  pend_size;

    ahb3lite_sram_slave #(.MEM_SIZE(64), .HADDR_SIZE(16), .HDATA_SIZE(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    function automatic vec_t mk(bit sel, logic [1:0] trans, bit ready, bit write, logic [2:0] size,
                                logic [15:0] addr, logic [31:0] wdata, bit chk, logic [31:0] exp);
        vec_t v;
        v.sel = sel; v.trans = trans; v.ready = ready; v.write = write; v.size = size;
        v.addr = addr; v.wdata = wdata; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t wr(logic [15:0] a, logic [31:0] d, logic [2:0] s = 3'd2, logic [1:0] t = 2'b10);
        return mk(1'b1, t, 1'b1, 1'b1, s, a, d, 1'b0, 32'h0);
    endfunction

    function automatic vec_t rd(logic [15:0] a, logic [31:0] e, logic [2:0] s = 3'd2, logic [1:0] t = 2'b10);
        return mk(1'b1, t, 1'b1, 1'b0, s, a, 32'h0, 1'b1, e);
    endfunction

    function automatic vec_t idle();
        return mk(1'b1, 2'b00, 1'b1, 1'b0, 3'd2, 16'h0, 32'h0, 1'b0, 32'h0);
    endfunction

    function automatic void mwrite(logic [15:0] a, logic [2:0] s, logic [31:0] d);
        int n     = (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
        int base  = int'(a[5:2]) * 4;
        int first = (int'(a[1:0]) / n) * n;
        for (int i = first; i < first + n; i++) mem_m[base + i] = d[i*8 +: 8];
    endfunction

    function automatic logic [31:0] mword(logic [15:0] a);
        int base = int'(a[5:2]) * 4;
        return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One bus cycle: address phase of v, data phase (HWDATA) of the previous beat.
    task automatic beat(input vec_t v, input string tag);
        bit acc;
        acc = v.sel && v.ready && v.trans[1];
        if (pend_w) mwrite(pend_addr, pend_size, prev_wdata);
        HWDATA = prev_wdata;
        HSEL   = v.sel;
        HTRANS = v.trans;
        HREADY = v.ready;
        HWRITE = v.write;
        HSIZE  = v.size;
        HADDR  = v.addr;
        HBURST = (v.trans == 2'b11) ? 3'b011 : 3'b000;
        if (acc && !v.write) rdq.push_back(mword(v.addr));
        pend_w     = acc && v.write;
        pend_addr  = v.addr;
        pend_size  = v.size;
        prev_wdata = v.wdata;
        @(posedge HCLK);
        #1;
        if (acc && !v.write) begin
            if (rdq.size() == 0) begin
                failures++;
                $display("FAIL %s scoreboard empty", tag);
            end else begin
                last_rd = rdq.pop_front();
            end
        end
        chk({tag, " hrdata"}, HRDATA, last_rd);
        chk({tag, " hreadyout"}, {31'b0, HREADYOUT}, 32'h1);
        chk({tag, " hresp"}, {31'b0, HRESP}, 32'h0);
        if (v.chk) chk({tag, " expect"}, HRDATA, v.exp);
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1; HWRITE = 1'b0;
        HSIZE = 3'd2; HBURST = 3'b000; HPROT = 4'b0011; HADDR = 16'h0; HWDATA = 32'h0;
        last_rd = 32'h0; prev_wdata = 32'h0; pend_w = 1'b0; pend_addr = 16'h0; pend_size = 3'd0;
        foreach (mem_m[i]) mem_m[i] = 8'h00;

        repeat (2) @(posedge HCLK);
        #1;
        chk("reset hrdata", HRDATA, 32'h0);
        chk("reset hreadyout", {31'b0, HREADYOUT}, 32'h1);
        chk("reset hresp", {31'b0, HRESP}, 32'h0);
        HRESET = 1'b0;

        tbl.push_back(wr(16'h0004, 32'hDEADBEEF));
        tbl.push_back(rd(16'h0004, 32'hDEADBEEF));
        tbl.push_back(wr(16'h0008, 32'h11223344));
        tbl.push_back(wr(16'h0009, 32'h0000AA00, 3'd0));
        tbl.push_back(rd(16'h0008, 32'h1122AA44));
        tbl.push_back(wr(16'h000C, 32'h00000000));
        tbl.push_back(wr(16'h000E, 32'hBEEF0000, 3'd1));
        tbl.push_back(idle());
        tbl.push_back(rd(16'h000C, 32'hBEEF0000));
        tbl.push_back(wr(16'h0010, 32'hCAFEF00D));
        tbl.push_back(mk(1'b1, 2'b00, 1'b1, 1'b1, 3'd2, 16'h0010, 32'h12345678, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 2'b01, 1'b1, 1'b1, 3'd2, 16'h0010, 32'h12345678, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 2'b10, 1'b1, 1'b1, 3'd2, 16'h0010, 32'h12345678, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 2'b10, 1'b0, 1'b1, 3'd2, 16'h0010, 32'h12345678, 1'b0, 32'h0));
        tbl.push_back(rd(16'h0010, 32'hCAFEF00D));
        tbl.push_back(wr(16'h0014, 32'h01010101));
        tbl.push_back(mk(1'b1, 2'b10, 1'b0, 1'b1, 3'd2, 16'h0014, 32'hFFFFFFFF, 1'b0, 32'h0));
        tbl.push_back(idle());
        tbl.push_back(rd(16'h0014, 32'h01010101));
        tbl.push_back(wr(16'h0020, 32'h1));
        tbl.push_back(wr(16'h0024, 32'h2, 3'd2, 2'b11));
        tbl.push_back(wr(16'h0028, 32'h3, 3'd2, 2'b11));
        tbl.push_back(wr(16'h002C, 32'h4, 3'd2, 2'b11));
        tbl.push_back(rd(16'h0028, 32'h3));
        tbl.push_back(rd(16'h002C, 32'h4, 3'd2, 2'b11));
        tbl.push_back(rd(16'h0020, 32'h1, 3'd2, 2'b11));
        tbl.push_back(rd(16'h0024, 32'h2, 3'd2, 2'b11));
        tbl.push_back(wr(16'h0040, 32'h00000055));
        tbl.push_back(rd(16'h0000, 32'h00000055));
        tbl.push_back(idle());
        tbl.push_back(rd(16'h0000, 32'h00000055));
        tbl.push_back(wr(16'h0030, 32'hA1B2C3D4));
        tbl.push_back(idle());
        tbl.push_back(rd(16'h0032, 32'hA1B2C3D4, 3'd1));
        tbl.push_back(wr(16'h0034, 32'h00000000));
        tbl.push_back(wr(16'h0035, 32'h00007788, 3'd1));
        tbl.push_back(idle());
        tbl.push_back(rd(16'h0034, 32'h00007788));
        tbl.push_back(wr(16'h003B, 32'h99887766));
        tbl.push_back(rd(16'h0038, 32'h99887766));
        tbl.push_back(wr(16'h003C, 32'h01020304));
        tbl.push_back(wr(16'h003F, 32'hEE000000, 3'd0));
        tbl.push_back(idle());
        tbl.push_back(rd(16'h003C, 32'hEE020304));

        foreach (tbl[i]) beat(tbl[i], $sformatf("vec%0d", i));
        beat(idle(), "flush");

        // Reset asserted during the data phase of a write: the write must not land.
        beat(wr(16'h0018, 32'h11111111), "rst_w0");
        beat(rd(16'h0018, 32'h11111111), "rst_r0");
        beat(wr(16'h0018, 32'h22222222), "rst_w1");
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h22222222;
        #2 HRESET = 1'b1;
        #1;
        chk("async reset hrdata", HRDATA, 32'h0);
        chk("async reset hreadyout", {31'b0, HREADYOUT}, 32'h1);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        pend_w = 1'b0; last_rd = 32'h0; prev_wdata = 32'h0;
        beat(idle(), "post_rst_idle");
        beat(rd(16'h0018, 32'h11111111), "post_rst_rd");
        beat(wr(16'h001C, 32'h5A5A5A5A), "post_rst_w");
        beat(rd(16'h001C, 32'h5A5A5A5A), "post_rst_fwd");
        beat(idle(), "end");

        if (rdq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard leftover entries=%0d", rdq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
